noc_packet_injector: RTL and testbench
======================================

// Module: noc_packet_injector
// PURPOSE
//  Clocked upstream feeder of the node's packet splitter. Accepts (data, dest address)
//  pairs from local logic and packs them into 11-bit packets {data[6:0], addr[3:0]}.
//  Buffers packets in a small FIFO and presents them on a valid/ready port.
//  That port feeds the async wrapper that drives the splitter's 11-bit input channel.
// PARAMETERS
//  DEPTH      4   FIFO entries; power of two, 2..16
//  NUM_NODES  16  valid destinations are 0..NUM_NODES-1; range 1..16
// PORTS
//  clk           in   1   single clock; all state updates on posedge
//  rst_n         in   1   reset, asynchronous, active-low
//  in_valid      in   1   local request valid
//  in_ready      out  1   injector can accept this cycle
//  in_data       in   7   payload
//  in_addr       in   4   destination node
//  pkt_valid     out  1   packet available
//  pkt_ready     in   1   downstream accepts
//  pkt_data      out  11  [10:4]=data, [3:0]=addr
//  err_bad_addr  out  1   sticky: an out-of-range address was dropped
//  pkt_count     out  16  packets sent (only with INJ_STATS_EN)
// BEHAVIOUR
//  - Reset (rst_n low, any time, async): FIFO empty, pointers 0, pkt_valid=0,
//    in_ready=0 while rst_n low, err_bad_addr=0, pkt_count=0. pkt_data=0 when empty.
//    A reset mid-transfer discards all buffered packets.
//  - in_ready = rst_n && !full. Push on posedge when in_valid && in_ready.
//    in_ready does NOT include same-cycle pop when full (no pass-through).
//  - Address check on push: in_addr >= NUM_NODES -> handshake completes, word dropped
//    (no FIFO write), err_bad_addr set to 1 next cycle, held until reset.
//  - pkt_valid = !empty; pkt_data = head entry, driven straight from FIFO storage.
//  - Pop on posedge when pkt_valid && pkt_ready.
//  - While pkt_valid && !pkt_ready, pkt_data is held stable.
//  - Latency: push at edge N into an empty FIFO -> pkt_valid=1 after edge N.
//    Minimum 1 cycle from accept to offer.
//  - Simultaneous push+pop (not full, not empty): count unchanged, both pointers advance.
//  - Push when empty + pkt_ready=1: no pop that cycle (FIFO was empty); packet offered next cycle.
//  - Pointers are log2(DEPTH)+1 bits with wrap bit. full = MSBs differ and low bits equal.
//    empty = pointers equal. Wrap-around is natural modulo 2*DEPTH.
//  - Order preserved: strict FIFO, no reordering, no duplication.
// CONFIGURATION
//  INJ_STATS_EN defined:
//   - pkt_count port exists.
//   - Increments on each pkt_valid && pkt_ready.
//   - Saturates at 16'hFFFF; reset to 0.
//  INJ_STATS_EN undefined: port and counter logic absent; all other behaviour identical.
// STRUCTURE
//  - Package noc_pkg:
//     - DATA_W=7, ADDR_W=4, PKT_W=11.
//     - typedef struct packed {logic [6:0] data; logic [3:0] addr;} noc_pkt_t.
//     - function pack_pkt(data, addr).
//     - Shared with the splitter side.
//  - Sub-module inj_fifo #(WIDTH=PKT_W, DEPTH): storage, pointers, full/empty.
//  - Top module: address check, packing, error flag, optional counter.
// TESTING
//  1. Reset, then push (data=7'h2A, addr=4'h5) -> next cycle pkt_valid=1, pkt_data=11'h2A5.
//     Pop -> pkt_valid=0.
//  2. pkt_ready=0, push 4 packets 0x01..0x04 with addr 1..4 -> in_ready=0 after the 4th.
//     Then pkt_ready=1 -> packets out in order 0x011,0x022,0x033,0x044.
//     in_ready rises after the first pop.
//  3. Back-to-back in_valid=1, pkt_ready=1 for 20 cycles -> one packet per cycle.
//     Pointers wrap past DEPTH; output order matches input order.
//  4. NUM_NODES=8, push addr=4'h9 -> accepted but not emitted; err_bad_addr=1 and stays set.
//     Next valid push is emitted normally.
//  5. FIFO holds 3 packets, drop rst_n mid-cycle -> pkt_valid=0 and in_ready=0 immediately.
//     After release the FIFO is empty and the flag is clear.
//  6. INJ_STATS_EN: send 5 packets, with a 3-cycle pkt_ready stall -> pkt_count=5.
//     Force counter to 16'hFFFE, send 3 -> pkt_count=16'hFFFF.

Source files
------------

// File: rtl/noc_packet_injector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared packet format for the injector and the splitter side.
//                A packet is {data[6:0], addr[3:0]}, data in the upper bits.
//  Revision    : 1.0  initial release
// ============================================================================
package noc_pkg;

    localparam int DATA_W = 7;
    localparam int ADDR_W = 4;
    localparam int PKT_W  = 11;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } noc_pkt_t;

    // Build a packet from its payload and destination fields
    function automatic noc_pkt_t pack_pkt(input logic [DATA_W-1:0] data,
                                          input logic [ADDR_W-1:0] addr);
        noc_pkt_t p;
        p.data = data;
        p.addr = addr;
        return p;
    endfunction

endpackage : noc_pkg
`default_nettype wire

// File: rtl/noc_packet_injector_if.sv
`default_nettype none
// ============================================================================
//  Module      : noc_packet_injector_if
//  Description : Request side (in_*) and packet side (pkt_*) handshakes of the
//                packet injector. master = local logic / downstream sink,
//                slave = the injector itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface noc_packet_injector_if;

    logic                       in_valid;
    logic                       in_ready;
    logic [noc_pkg::DATA_W-1:0] in_data;
    logic [noc_pkg::ADDR_W-1:0] in_addr;
    logic                       pkt_valid;
    logic                       pkt_ready;
    logic [noc_pkg::PKT_W-1:0]  pkt_data;

    modport master (
        output in_valid, in_data, in_addr, pkt_ready,
        input  in_ready, pkt_valid, pkt_data
    );

    modport slave (
        input  in_valid, in_data, in_addr, pkt_ready,
        output in_ready, pkt_valid, pkt_data
    );

endinterface : noc_packet_injector_if
`default_nettype wire

// File: rtl/noc_packet_injector_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : inj_fifo
//  Description : Packet buffer with wrap-bit pointers. Read data comes straight
//                from storage and is forced to zero while the buffer is empty.
//  Revision    : 1.0  initial release
// ============================================================================
module inj_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] wdata,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_aw:0] c_ptr_one = (c_aw+1)'(1);

    logic [c_aw:0]      wr_ptr_q, wr_ptr_d;
    logic [c_aw:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic               do_push;
    logic               do_pop;

    assign full    = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                     (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q[c_aw-1:0]];

    // Next pointers and storage contents
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (do_push) begin
            wr_ptr_d                      = wr_ptr_q + c_ptr_one;
            mem_d[wr_ptr_q[c_aw-1:0]]     = wdata;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
    end

    // Pointer registers; reset empties the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: it is only visible through a non-empty pointer pair
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule : inj_fifo
`default_nettype wire

// File: rtl/noc_packet_injector.sv
`default_nettype none
// ============================================================================
//  Module      : noc_packet_injector
//  Description : Packs (data, addr) requests into 11-bit packets, drops and
//                flags out-of-range destinations, buffers the rest and offers
//                them on a valid/ready port.
//                Optional macro INJ_STATS_EN adds the saturating pkt_count port.
//  Revision    : 1.0  initial release
// ============================================================================
module noc_packet_injector
    import noc_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int NUM_NODES = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    noc_packet_injector_if.slave   bus,
`ifdef INJ_STATS_EN
    output logic [15:0]            pkt_count,
`endif
    output logic                   err_bad_addr
);

    localparam logic [ADDR_W:0] c_num_nodes = (ADDR_W+1)'(NUM_NODES);

    noc_pkt_t   pkt_w;
    logic       addr_ok_w;
    logic       in_hs_w;
    logic       fifo_push_w;
    logic       fifo_pop_w;
    logic       fifo_full_w;
    logic       fifo_empty_w;
    logic       err_q, err_d;

    assign pkt_w        = pack_pkt(bus.in_data, bus.in_addr);
    assign addr_ok_w    = ({1'b0, bus.in_addr} < c_num_nodes);
    // No pass-through: a full buffer refuses even if a pop happens this cycle
    assign bus.in_ready = rst_n && !fifo_full_w;
    assign in_hs_w      = bus.in_valid && bus.in_ready;
    assign fifo_push_w  = in_hs_w && addr_ok_w;
    assign bus.pkt_valid = !fifo_empty_w;
    assign fifo_pop_w   = !fifo_empty_w && bus.pkt_ready;
    assign err_bad_addr = err_q;

    inj_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push_w),
        .wdata (pkt_w),
        .pop   (fifo_pop_w),
        .rdata (bus.pkt_data),
        .full  (fifo_full_w),
        .empty (fifo_empty_w)
    );

    // Sticky flag: set by any accepted request with a bad destination
    always_comb begin
        err_d = err_q | (in_hs_w && !addr_ok_w);
    end

    // Error flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

`ifdef INJ_STATS_EN
    logic [15:0] pkt_count_q, pkt_count_d;

    // Count delivered packets, saturating at all-ones
    always_comb begin
        pkt_count_d = pkt_count_q;
        if (fifo_pop_w && (pkt_count_q != 16'hFFFF)) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end
    end

    // Packet counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule : noc_packet_injector
`default_nettype wire

// File: tb/tb_noc_packet_injector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noc_packet_injector
//  Description : Self-checking bench for noc_packet_injector (DEPTH=4,
//                NUM_NODES=8) against a queue-based reference model.
//                Stats checks are compiled in with INJ_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_noc_packet_injector;

    localparam int DEPTH     = 4;
    localparam int NUM_NODES = 8;

    logic clk;
    logic rst_n;
    logic err_bad_addr;
`ifdef INJ_STATS_EN
    logic [15:0] pkt_count;
`endif

    noc_packet_injector_if bus ();

    noc_packet_injector #(
        .DEPTH     (DEPTH),
        .NUM_NODES (NUM_NODES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
`ifdef INJ_STATS_EN
        .pkt_count    (pkt_count),
`endif
        .err_bad_addr (err_bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: list of buffered packets, sticky flag, delivered count
    logic [10:0] mq[$];
    bit          m_err;
    int          m_cnt;

    function automatic logic [10:0] m_head();
        return (mq.size() > 0) ? mq[0] : 11'h000;
    endfunction

    // Drive one cycle of inputs, advance one clock, update the model
    task automatic step(input logic v, input logic [6:0] d, input logic [3:0] a, input logic r);
        bit acc;
        bit pop;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_addr   = a;
        bus.pkt_ready = r;
        acc = v && (mq.size() < DEPTH);
        pop = (mq.size() > 0) && r;
        @(posedge clk);
        if (pop) begin
            void'(mq.pop_front());
            if (m_cnt < 65535) m_cnt++;
        end
        if (acc) begin
            if (int'(a) < NUM_NODES) mq.push_back({d, a});
            else m_err = 1'b1;
        end
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_addr = '0; bus.pkt_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_pkt_valid: got %b want 0", bus.pkt_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.pkt_data !== 11'h000) begin errors++; $display("FAIL reset_pkt_data: got %h want 000", bus.pkt_data); end
        checks++; if (err_bad_addr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_bad_addr); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_single();
        step(1'b1, 7'h2A, 4'h5, 1'b1);
        checks++; if (bus.pkt_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.pkt_valid); end
        checks++; if (bus.pkt_data !== 11'h2A5) begin errors++; $display("FAIL single_data: got %h want 2a5", bus.pkt_data); end
        step(1'b0, 7'h00, 4'h0, 1'b1);
        checks++; if (bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b want 0", bus.pkt_valid); end
        checks++; if (bus.pkt_data !== 11'h000) begin errors++; $display("FAIL single_empty_data: got %h want 000", bus.pkt_data); end
    endtask

    task automatic test_fill_drain();
        logic [10:0] exp_pkts [4];
        exp_pkts[0] = 11'h011; exp_pkts[1] = 11'h022; exp_pkts[2] = 11'h033; exp_pkts[3] = 11'h044;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b want 1", i, bus.in_ready); end
            step(1'b1, 7'(i), 4'(i), 1'b0);
        end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
        // Request while full must be refused and the head held stable
        step(1'b1, 7'h55, 4'h1, 1'b0);
        checks++; if (bus.pkt_data !== 11'h011) begin errors++; $display("FAIL stall_hold: got %h want 011", bus.pkt_data); end
        // Ready while full: pop happens but in_ready stays low this cycle
        bus.in_valid = 1'b0; bus.pkt_ready = 1'b1; #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL no_passthru: got %b want 0", bus.in_ready); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus.pkt_data !== exp_pkts[k]) begin errors++; $display("FAIL drain_%0d: got %h want %h", k, bus.pkt_data, exp_pkts[k]); end
            step(1'b0, 7'h00, 4'h0, 1'b1);
            if (k == 0) begin
                checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop: got %b want 1", bus.in_ready); end
            end
        end
        checks++; if (bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL drained_valid: got %b want 0", bus.pkt_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                checks++; if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== m_head()) begin
                    errors++; $display("FAIL b2b_%0d: got v=%b d=%h want v=1 d=%h", i, bus.pkt_valid, bus.pkt_data, m_head());
                end
            end
            step(1'b1, 7'($urandom_range(0, 127)), 4'($urandom_range(0, NUM_NODES-1)), 1'b1);
        end
        checks++; if (bus.pkt_data !== m_head()) begin errors++; $display("FAIL b2b_last: got %h want %h", bus.pkt_data, m_head()); end
        step(1'b0, 7'h00, 4'h0, 1'b1);
        checks++; if (bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", bus.pkt_valid); end
    endtask

    task automatic test_bad_addr();
        step(1'b1, 7'h33, 4'h9, 1'b1);
        checks++; if (err_bad_addr !== 1'b1) begin errors++; $display("FAIL bad_err_set: got %b want 1", err_bad_addr); end
        checks++; if (bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL bad_not_emitted: got %b want 0", bus.pkt_valid); end
        step(1'b1, 7'h44, 4'h8, 1'b1);
        checks++; if (bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL bad_addr8: got %b want 0", bus.pkt_valid); end
        repeat (3) step(1'b0, 7'h00, 4'h0, 1'b1);
        checks++; if (err_bad_addr !== 1'b1) begin errors++; $display("FAIL bad_err_sticky: got %b want 1", err_bad_addr); end
        step(1'b1, 7'h12, 4'h7, 1'b0);
        checks++; if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== 11'h127) begin
            errors++; $display("FAIL good_after_bad: got v=%b d=%h want v=1 d=127", bus.pkt_valid, bus.pkt_data);
        end
        step(1'b0, 7'h00, 4'h0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            checks++; if (bus.pkt_valid !== (mq.size() > 0) || bus.pkt_data !== m_head() ||
                          bus.in_ready !== (mq.size() < DEPTH) || err_bad_addr !== m_err) begin
                errors++; $display("FAIL rand_%0d: got v=%b d=%h r=%b e=%b want v=%b d=%h r=%b e=%b", i,
                    bus.pkt_valid, bus.pkt_data, bus.in_ready, err_bad_addr,
                    mq.size() > 0, m_head(), mq.size() < DEPTH, m_err);
            end
        end
        while (mq.size() > 0) step(1'b0, 7'h00, 4'h0, 1'b1);
    endtask

    task automatic test_async_reset();
        step(1'b1, 7'h01, 4'hF, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 7'(i + 5), 4'(i), 1'b0);
        bus.in_valid = 1'b0;
        checks++; if (bus.pkt_valid !== 1'b1 || err_bad_addr !== 1'b1) begin
            errors++; $display("FAIL prerst: got v=%b e=%b want v=1 e=1", bus.pkt_valid, err_bad_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", bus.pkt_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL async_ready: got %b want 0", bus.in_ready); end
        model_reset();
        @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        checks++; if (bus.pkt_valid !== 1'b0 || err_bad_addr !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL post_rst: got v=%b e=%b r=%b want 0 0 1", bus.pkt_valid, err_bad_addr, bus.in_ready);
        end
        step(1'b1, 7'h3C, 4'h2, 1'b0);
        checks++; if (bus.pkt_data !== 11'h3C2) begin errors++; $display("FAIL post_rst_data: got %h want 3c2", bus.pkt_data); end
        step(1'b0, 7'h00, 4'h0, 1'b1);
    endtask

`ifdef INJ_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0; #2; rst_n = 1'b1; model_reset();
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL cnt_reset: got %h want 0", pkt_count); end
        for (int i = 0; i < 5; i++) step(1'b1, 7'(i), 4'(i), (i >= 2));
        repeat (3) step(1'b0, 7'h00, 4'h0, 1'b0);
        while (mq.size() > 0) step(1'b0, 7'h00, 4'h0, 1'b1);
        checks++; if (pkt_count !== 16'd5) begin errors++; $display("FAIL cnt_five: got %0d want 5", pkt_count); end
        dut.pkt_count_q = 16'hFFFE;
        for (int i = 0; i < 3; i++) step(1'b1, 7'(i), 4'h1, 1'b1);
        step(1'b0, 7'h00, 4'h0, 1'b1);
        checks++; if (pkt_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat: got %h want ffff", pkt_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_bad_addr();
        test_random();
        test_async_reset();
`ifdef INJ_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_noc_packet_injector
`default_nettype wire
